// File: rtl/keccak_ctrl.sv
//==============================================================================
// Module      : keccak_ctrl
// Description : Sequencing controller for an iterative Keccak permutation core.
//               Walks IDLE -> LOAD -> ROUND x NUM_ROUNDS -> STORE -> IDLE and
//               keeps sticky done/err flags plus a level interrupt.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module keccak_ctrl #(
  parameter int NUM_ROUNDS = 24,
  parameter int RIDX_W     = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              clear_i,
  input  logic              intr_en_i,
  output logic              load_o,
  output logic              round_en_o,
  output logic [RIDX_W-1:0] round_idx_o,
  output logic              last_round_o,
  output logic              store_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              intr_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    STORE = 2'd3
  } state_t;

  localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NUM_ROUNDS - 1);

  state_t            state;
  logic [RIDX_W-1:0] round_ctr;
  logic              done_q;
  logic              err_q;

  // Single state machine: sequencing, round counter and sticky flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      round_ctr <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // A rejected start must be visible even if software clears in the same cycle
      if ((state != IDLE) && start_i) begin
        err_q <= 1'b1;
      end else if (clear_i) begin
        err_q <= 1'b0;
      end

      // Completion beats a coincident clear; an abort in STORE never completes
      if ((state == STORE) && !abort_i) begin
        done_q <= 1'b1;
      end else if (clear_i || ((state == IDLE) && start_i && !abort_i)) begin
        done_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          round_ctr <= '0;
          if (start_i && !abort_i) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          round_ctr <= '0;
          state     <= abort_i ? IDLE : ROUND;
        end
        ROUND: begin
          if (abort_i) begin
            state     <= IDLE;
            round_ctr <= '0;
          end else if (round_ctr == LAST_IDX) begin
            state     <= STORE;
            round_ctr <= '0;
          end else begin
            round_ctr <= round_ctr + RIDX_W'(1);
          end
        end
        STORE: begin
          state     <= IDLE;
          round_ctr <= '0;
        end
        default: begin
          state     <= IDLE;
          round_ctr <= '0;
        end
      endcase
    end
  end

  // Core strobes are pure decodes of registered state, so inputs never reach them
  assign load_o       = (state == LOAD);
  assign round_en_o   = (state == ROUND);
  assign store_o      = (state == STORE);
  assign busy_o       = (state != IDLE);
  assign round_idx_o  = (state == ROUND) ? round_ctr : '0;
  assign last_round_o = (state == ROUND) && (round_ctr == LAST_IDX);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign intr_o       = done_q & intr_en_i;

endmodule

`default_nettype wire

// File: doc/keccak_ctrl.md
KECCAK_CTRL -- requirements
Module: keccak_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 24, number of permutation rounds per run; legal range 1..31.
REQ-002 SHALL have parameter RIDX_W, default 5, width of round index; SHALL satisfy 2^RIDX_W > NUM_ROUNDS.
REQ-003 SHALL use one clock `clk_i`, input, 1, rising-edge clock for all state.
REQ-004 SHALL use reset `rst_ni`, input, 1, asynchronous active-low reset.
REQ-005 SHALL have `start_i`, input, 1, single-cycle pulse from a CTRL.START register write.
REQ-006 SHALL have `abort_i`, input, 1, single-cycle pulse from a CTRL.ABORT register write.
REQ-007 SHALL have `clear_i`, input, 1, single-cycle pulse from a STATUS write-1-to-clear.
REQ-008 SHALL have `intr_en_i`, input, 1, level interrupt enable.
REQ-009 SHALL have `load_o`, output, 1, pulse instructing the core to latch the input state from data registers.
REQ-010 SHALL have `round_en_o`, output, 1, core executes one round this cycle.
REQ-011 SHALL have `round_idx_o`, output, RIDX_W, current round index, used for round-constant selection.
REQ-012 SHALL have `last_round_o`, output, 1, high with round_en_o on the final round.
REQ-013 SHALL have `store_o`, output, 1, pulse instructing the core to write the state into output registers.
REQ-014 SHALL have `busy_o`, output, 1, run in progress; data-register bus writes are blocked while high.
REQ-015 SHALL have `done_o`, output, 1, sticky completion flag.
REQ-016 SHALL have `err_o`, output, 1, sticky flag set by start while busy.
REQ-017 SHALL have `intr_o`, output, 1, level interrupt, equal to done_o AND intr_en_i.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, ROUND, STORE.
REQ-019 IDLE + start_i SHALL go to LOAD; LOAD SHALL go to ROUND after exactly 1 cycle; ROUND SHALL go to STORE after NUM_ROUNDS cycles; STORE SHALL go to IDLE after exactly 1 cycle.
REQ-020 load_o SHALL be high only in LOAD, round_en_o only in ROUND, and store_o only in STORE; all three SHALL be registered-state decodes, with no combinational path from the inputs.
REQ-021 The round counter SHALL be 0 on entry to ROUND and increment by 1 per ROUND cycle; round_idx_o SHALL equal the counter in ROUND and 0 otherwise.
REQ-022 last_round_o SHALL be high iff state==ROUND and counter==NUM_ROUNDS-1.
REQ-023 The counter SHALL never exceed NUM_ROUNDS-1, with no wrap-around.
REQ-024 busy_o SHALL be high iff state != IDLE.
REQ-025 Latency: with start_i high in IDLE at cycle 0 → LOAD at cycle 1; ROUND at cycles 2..NUM_ROUNDS+1; STORE at cycle NUM_ROUNDS+2; IDLE with done_o=1 at cycle NUM_ROUNDS+3 (27 for the default).
REQ-026 done_o SHALL be set on the STORE→IDLE transition, and cleared by clear_i or by an accepted start_i.
REQ-027 When clear_i and the STORE→IDLE transition occur in the same cycle, the set SHALL win and done_o SHALL be 1.
REQ-028 start_i while busy_o=1 SHALL be ignored, with no effect on state or counter, and SHALL set err_o; err_o SHALL be cleared only by clear_i.
REQ-029 When start_i while busy and clear_i occur in the same cycle, err_o SHALL be 1.
REQ-030 abort_i in LOAD, ROUND or STORE SHALL force IDLE the next cycle and reset the counter to 0; it SHALL not set done_o, SHALL not assert store_o, and SHALL leave err_o unchanged.
REQ-031 abort_i in IDLE SHALL be a no-op.
REQ-032 When abort_i and start_i arrive in the same cycle, abort SHALL win: a start in IDLE is not accepted, and start while busy still sets err_o.
REQ-033 intr_en_i toggling SHALL affect intr_o combinationally and SHALL not alter done_o.

Reset
REQ-034 On rst_ni=0, asynchronously: state=IDLE, counter=0, done_o=0, err_o=0.
REQ-035 During reset, all outputs SHALL be 0.
REQ-036 Reset deassertion mid-run SHALL leave the block in IDLE, with no store_o pulse.
REQ-037 The first start_i SHALL be accepted on the first rising edge after deassertion.

Verification
REQ-038 Start pulse at cycle 0, NUM_ROUNDS=24 → load_o at cycle 1; round_idx 0..23 at cycles 2..25; last_round_o at cycle 25; store_o at cycle 26; done_o=1 and busy_o=0 at cycle 27; intr_o=1 with intr_en_i=1.
REQ-039 Second start_i at cycle 10 of a run → err_o=1; sequence timing unchanged; done_o at cycle 27; clear_i afterward → done_o=0, err_o=0.
REQ-040 abort_i at round_idx=7 → next cycle IDLE, round_idx_o=0, busy_o=0; no store_o; done_o stays 0; a new start then completes in 27 cycles.
REQ-041 clear_i in the STORE cycle → done_o=1 the following cycle; clear_i one cycle later → done_o=0.
REQ-042 rst_ni asserted at round_idx=12 → all outputs 0 immediately; after release, start_i at cycle 0 → done_o at cycle 27.
REQ-043 NUM_ROUNDS=1 build: start at cycle 0 → LOAD at 1, single ROUND with last_round_o=1 at 2, STORE at 3, done_o at 4.
